// File: rtl/conv_mul_arb_pkg.sv
// Shared constants and pipeline stage record for the Conv multiplier arbiter.
package conv_mul_arb_pkg;

   localparam int unsigned A_W       = 16;
   localparam int unsigned B_W       = 16;
   localparam int unsigned P_W       = 32;
   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned ID_W_MAX  = 3;

   // The product is formed at issue; later stages only carry it, so retiming can spread the DSP.
   typedef struct packed {
      logic                valid;
      logic [ID_W_MAX-1:0] id;
      logic [P_W-1:0]      p;
   } stage_t;

endpackage

// File: rtl/conv_mul_arb_rr.sv
// Round-robin grant: first asserted request at or after rr_ptr, wrapping modulo N_REQ.
module conv_mul_arb_rr #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             grant_any
);

   int unsigned k;

   // Scan from the farthest offset to the nearest so the nearest request writes last and wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      k         = 0;
      for (int unsigned j = 0; j < N_REQ; j++) begin
         k = (32'(rr_ptr) + N_REQ - 1 - j) % N_REQ;
         if (req[k]) begin
            grant     = '0;
            grant[k]  = 1'b1;
            grant_idx = ID_W'(k);
            grant_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_mul_share_arb.sv
// One pipelined signed x unsigned multiplier shared round-robin by N_REQ requesters.
// Define CONV_MUL_ARB_PERF_EN to add the perf_issue_cnt / perf_stall_cnt counters.
module conv_mul_share_arb
   import conv_mul_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned LAT   = 2,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*A_W-1:0] req_a,
   input  logic [N_REQ*B_W-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [P_W-1:0]       rsp_p,
   output logic [ID_W-1:0]      rsp_id
`ifdef CONV_MUL_ARB_PERF_EN
   ,
   output logic [31:0]          perf_issue_cnt,
   output logic [31:0]          perf_stall_cnt
`endif
);

   stage_t            pipe_q [LAT];
   stage_t            in_stage;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_any;
   logic              stall;
   logic              issue;
   logic [A_W-1:0]    sel_a;
   logic [B_W-1:0]    sel_b;
   logic signed [P_W-1:0] ext_a, ext_b;

   conv_mul_arb_rr #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign stall     = pipe_q[LAT-1].valid && !rsp_ready;
   assign issue     = grant_any && !stall;
   assign req_ready = stall ? '0 : grant;

   always_comb begin
      sel_a          = req_a[32'(grant_idx)*A_W +: A_W];
      sel_b          = req_b[32'(grant_idx)*B_W +: B_W];
      ext_a          = P_W'($signed(sel_a));
      ext_b          = P_W'(sel_b);
      in_stage.valid = issue;
      in_stage.id    = ID_W_MAX'(grant_idx);
      in_stage.p     = ext_a * ext_b;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         rr_ptr_q <= '0;
         for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (!stall) begin
            pipe_q[0] <= in_stage;
            for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
         end
      end
   end

   assign rsp_valid = pipe_q[LAT-1].valid;
   assign rsp_p     = pipe_q[LAT-1].p;
   assign rsp_id    = ID_W'(pipe_q[LAT-1].id);

`ifdef CONV_MUL_ARB_PERF_EN
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_mul_share_arb.sv
// Randomised scoreboard bench for conv_mul_share_arb against a queue-based reference model.
module tb_conv_mul_share_arb;

   localparam int N   = 4;
   localparam int LAT = 2;
   localparam int IDW = 2;

   logic             ap_clk = 1'b0;
   logic             ap_rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*16-1:0]  req_a;
   logic [N*16-1:0]  req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_p;
   logic [IDW-1:0]   rsp_id;
`ifdef CONV_MUL_ARB_PERF_EN
   logic [31:0]      perf_issue_cnt;
   logic [31:0]      perf_stall_cnt;
`endif

   logic [15:0] a_arr [N];
   logic [15:0] b_arr [N];

   typedef struct {
      int     id;
      longint p;
   } exp_t;

   exp_t   exp_q [$];
   int     flight_q [$];
   int     rr_model;
   longint model_issues;
   longint model_stalls;
   int     checks;
   int     failures;

   always #5 ap_clk = ~ap_clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[16*i +: 16] = a_arr[i];
         req_b[16*i +: 16] = b_arr[i];
      end
   end

   conv_mul_share_arb #(
      .N_REQ (N),
      .LAT   (LAT),
      .ID_W  (IDW)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .rsp_id    (rsp_id)
`ifdef CONV_MUL_ARB_PERF_EN
      ,
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   function automatic longint ref_mul(input logic [15:0] a, input logic [15:0] b);
      return longint'($signed(a)) * longint'(b);
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: rr pointer plus a queue of in-flight items with remaining cycles.
   always @(negedge ap_clk) begin
      bit           out_v;
      bit           st;
      int           win;
      logic [N-1:0] exp_ready;
      if (ap_rst) begin
         flight_q.delete();
         exp_q.delete();
         rr_model     = 0;
         model_issues = 0;
         model_stalls = 0;
      end else begin
         out_v     = (flight_q.size() > 0) && (flight_q[0] == 0);
         st        = out_v && !rsp_ready;
         win       = -1;
         exp_ready = '0;
         check("rsp_valid", longint'(rsp_valid), longint'(out_v));
         if (!st) begin
            for (int o = 0; o < N; o++) begin
               if (req_valid[(rr_model + o) % N]) begin
                  win = (rr_model + o) % N;
                  break;
               end
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
         check("req_ready", longint'(req_ready), longint'(exp_ready));
         if (st) begin
            model_stalls++;
            if (exp_q.size() > 0) begin
               check("hold_p", longint'($signed(rsp_p)), exp_q[0].p);
               check("hold_id", longint'(rsp_id), longint'(exp_q[0].id));
            end
         end else begin
            if (out_v) void'(flight_q.pop_front());
            foreach (flight_q[j]) if (flight_q[j] > 0) flight_q[j]--;
            if (win >= 0) begin
               flight_q.push_back(LAT - 1);
               exp_q.push_back('{win, ref_mul(a_arr[win], b_arr[win])});
               rr_model = (win + 1) % N;
               model_issues++;
            end
         end
      end
   end

   // Monitor: every accepted response must match the oldest outstanding expectation.
   always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=id%0d/p%0d required=none", rsp_id, $signed(rsp_p));
         end else begin
            e = exp_q.pop_front();
            check("rsp_id", longint'(rsp_id), longint'(e.id));
            check("rsp_p", longint'($signed(rsp_p)), e.p);
         end
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic wait_rsp(input string name, input int id, input longint p);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(negedge ap_clk);
         if (rsp_valid) begin
            seen = 1'b1;
            check({name, "_id"}, longint'(rsp_id), longint'(id));
            check({name, "_p"}, longint'($signed(rsp_p)), p);
         end
      end
      if (!seen) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic set_all(input logic [15:0] b);
      for (int i = 0; i < N; i++) begin
         a_arr[i] = 16'(i + 1);
         b_arr[i] = b;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] acc;
      checks    = 0;
      failures  = 0;
      ap_rst    = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         a_arr[i] = '0;
         b_arr[i] = '0;
      end
      repeat (3) tick();
      ap_rst = 1'b0;

      @(negedge ap_clk);
      check("reset_rsp_valid", longint'(rsp_valid), 0);
      check("reset_rsp_p", longint'(rsp_p), 0);
      check("reset_rsp_id", longint'(rsp_id), 0);
      tick();

      // Single request from requester 1
      a_arr[1]  = 16'hFFFD;
      b_arr[1]  = 16'hFFFF;
      req_valid = 4'b0010;
      @(negedge ap_clk);
      check("single_ready", longint'(req_ready), 4'b0010);
      tick();
      req_valid = '0;
      wait_rsp("single", 1, -196605);
      tick();

      // Everyone requesting continuously
      set_all(16'd10);
      req_valid = '1;
      repeat (12) tick();
      req_valid = '0;
      repeat (4) tick();

      // Full pipeline, then 5 cycles of backpressure
      req_valid = '1;
      repeat (4) tick();
      rsp_ready = 1'b0;
      repeat (5) tick();
      rsp_ready = 1'b1;
      repeat (3) tick();
      req_valid = '0;
      repeat (4) tick();

      // Operand extremes
      a_arr[0]  = 16'h8000;
      b_arr[0]  = 16'hFFFF;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      wait_rsp("min", 0, -2147450880);
      tick();
      a_arr[0]  = 16'h7FFF;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      wait_rsp("max", 0, 2147385345);
      tick();

      // Reset with two products in flight
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      repeat (2) tick();
      req_valid = '0;
      ap_rst    = 1'b1;
      tick();
      ap_rst    = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge ap_clk);
         check("post_reset_quiet", longint'(rsp_valid), 0);
      end
      tick();
      req_valid = '1;
      @(negedge ap_clk);
      check("post_reset_grant", longint'(req_ready), 4'b0001);
      tick();
      req_valid = '0;
      repeat (4) tick();

      // Randomised traffic with random backpressure and request drops
      for (int c = 0; c < 1500; c++) begin
         @(negedge ap_clk);
         acc = req_valid & req_ready;
         @(posedge ap_clk);
         #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !acc[i]) begin
               if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
            end else begin
               req_valid[i] = 1'($urandom_range(0, 1));
               a_arr[i]     = 16'($urandom);
               b_arr[i]     = 16'($urandom);
            end
         end
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (8) tick();
      @(negedge ap_clk);
      check("drained", longint'(exp_q.size()), 0);

`ifdef CONV_MUL_ARB_PERF_EN
      check("perf_issue_model", longint'(perf_issue_cnt), model_issues % (64'd1 << 32));
      check("perf_stall_model", longint'(perf_stall_cnt), model_stalls % (64'd1 << 32));
      tick();
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("perf_issue_reset", longint'(perf_issue_cnt), 0);
      check("perf_stall_reset", longint'(perf_stall_cnt), 0);
      tick();
      req_valid = 4'b0001;
      repeat (7) tick();
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (3) tick();
      rsp_ready = 1'b1;
      repeat (4) tick();
      @(negedge ap_clk);
      check("perf_issue_7", longint'(perf_issue_cnt), 7);
      check("perf_stall_3", longint'(perf_stall_cnt), 3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
